// File: rtl/muldiv_seq_ctrl_if.sv
// Request/response bundle between the EX stage and the iterative multiply/divide sequencer.
// The EX side drives operands and flush; the sequencer returns stall, busy and the result pulse.
interface muldiv_seq_ctrl_if #(
    parameter int XLEN = 32
);
    logic            req_i;
    logic [1:0]      op_i;
    logic [XLEN-1:0] src1_i;
    logic [XLEN-1:0] src2_i;
    logic            flush_i;
    logic            stall_o;
    logic            busy_o;
    logic            done_o;
    logic [XLEN-1:0] result_o;

    modport master (
        output req_i, op_i, src1_i, src2_i, flush_i,
        input  stall_o, busy_o, done_o, result_o
    );

    modport slave (
        input  req_i, op_i, src1_i, src2_i, flush_i,
        output stall_o, busy_o, done_o, result_o
    );
endinterface

// File: rtl/muldiv_seq_ctrl.sv
// Iterative unsigned MUL/MULHU/DIVU/REMU sequencer beside the EX-stage ALU.
// One shift-add or restoring-divide step per cycle; the pipeline is stalled until the result pulse.
module muldiv_seq_ctrl #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic              clk_i,
    input  logic              rst_i,
    muldiv_seq_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [1:0]        op;
    logic [XLEN-1:0]   mcand;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   divisor;
    logic [XLEN-1:0]   rem;
    logic [XLEN-1:0]   quot;
    logic [XLEN-1:0]   result;

    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] prod_nxt;
    logic [XLEN:0]     rem_sh;
    logic              sub_ok;
    logic [XLEN-1:0]   diff;
    logic [XLEN-1:0]   rem_nxt;
    logic [XLEN-1:0]   quot_nxt;
    logic              last;

    // When the trial subtract succeeds the difference is below the divisor, so XLEN bits hold it.
    always_comb begin
        mul_sum  = {1'b0, prod[2*XLEN-1:XLEN]} + (prod[0] ? {1'b0, mcand} : '0);
        prod_nxt = {mul_sum, prod[XLEN-1:1]};
        rem_sh   = {rem, quot[XLEN-1]};
        sub_ok   = rem_sh >= {1'b0, divisor};
        diff     = rem_sh[XLEN-1:0] - divisor;
        rem_nxt  = sub_ok ? diff : rem_sh[XLEN-1:0];
        quot_nxt = {quot[XLEN-2:0], sub_ok};
        last     = (cnt == CNT_W'(XLEN-1));
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state   <= IDLE;
            cnt     <= '0;
            op      <= '0;
            mcand   <= '0;
            prod    <= '0;
            divisor <= '0;
            rem     <= '0;
            quot    <= '0;
            result  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_i && !bus.flush_i) begin
                        op      <= bus.op_i;
                        cnt     <= '0;
                        mcand   <= bus.src1_i;
                        prod    <= {{XLEN{1'b0}}, bus.src2_i};
                        divisor <= bus.src2_i;
                        rem     <= '0;
                        quot    <= bus.src1_i;
                        if (!bus.op_i[1]) begin
                            state <= MUL;
                        end else if (bus.src2_i != '0) begin
                            state <= DIV;
                        end else begin
                            // Divide by zero finishes at once with the RISC-V defined results.
                            state  <= DONE;
                            result <= bus.op_i[0] ? bus.src1_i : '1;
                        end
                    end
                end
                MUL: begin
                    if (bus.flush_i) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        prod <= prod_nxt;
                        cnt  <= cnt + 1'b1;
                        if (last) begin
                            state  <= DONE;
                            result <= op[0] ? prod_nxt[2*XLEN-1:XLEN] : prod_nxt[XLEN-1:0];
                        end
                    end
                end
                DIV: begin
                    if (bus.flush_i) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        rem  <= rem_nxt;
                        quot <= quot_nxt;
                        cnt  <= cnt + 1'b1;
                        if (last) begin
                            state  <= DONE;
                            result <= op[0] ? rem_nxt : quot_nxt;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Stall drops in DONE so the instruction holding the result can advance into EX/MEM.
    assign bus.stall_o  = ((state == IDLE) && bus.req_i && !bus.flush_i) ||
                          (state == MUL) || (state == DIV);
    assign bus.busy_o   = (state == MUL) || (state == DIV);
    assign bus.done_o   = (state == DONE);
    assign bus.result_o = result;

endmodule
